// File: rtl/xsim_dma_arbiter.sv
// Shares one xsim DMA port between NCLIENTS requesters: round-robin write and
// read channels, writes win ties, one outstanding read routed back to its issuer.
module xsim_dma_arbiter #(
  parameter int NCLIENTS     = 4,
  parameter int MAX_WR_BURST = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCLIENTS-1:0]      cli_rd_valid,
  output logic [NCLIENTS-1:0]      cli_rd_ready,
  input  logic [32*NCLIENTS-1:0]   cli_rd_addr,
  input  logic [32*NCLIENTS-1:0]   cli_rd_handle,
  output logic [NCLIENTS-1:0]      cli_rsp_valid,
  input  logic [NCLIENTS-1:0]      cli_rsp_ready,
  output logic [31:0]              cli_rsp_data,
  input  logic [NCLIENTS-1:0]      cli_wr_valid,
  output logic [NCLIENTS-1:0]      cli_wr_ready,
  input  logic [32*NCLIENTS-1:0]   cli_wr_addr,
  input  logic [32*NCLIENTS-1:0]   cli_wr_handle,
  input  logic [32*NCLIENTS-1:0]   cli_wr_data,
  input  logic                     dma_rdy_readrequest,
  output logic                     dma_en_readrequest,
  output logic [31:0]              dma_readrequest_addr,
  output logic [31:0]              dma_readrequest_handle,
  input  logic                     dma_rdy_readresponse,
  output logic                     dma_en_readresponse,
  input  logic [31:0]              dma_readresponse_data,
  output logic                     dma_en_write32,
  output logic [31:0]              dma_write32_addr,
  output logic [31:0]              dma_write32_handle,
  output logic [31:0]              dma_write32_data,
  output logic [31:0]              rd_count,
  output logic [31:0]              wr_count,
  output logic                     busy
);

  localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_BUSY = 1'b1;

  logic [0:0]    state_reg;
  logic [IW-1:0] owner_reg;
  logic [IW-1:0] rd_last_reg;
  logic [IW-1:0] wr_last_reg;
  logic [7:0]    wr_burst_reg;
  logic [31:0]   rd_count_reg;
  logic [31:0]   wr_count_reg;

  logic [31:0] rd_addr_arr   [NCLIENTS];
  logic [31:0] rd_handle_arr [NCLIENTS];
  logic [31:0] wr_addr_arr   [NCLIENTS];
  logic [31:0] wr_handle_arr [NCLIENTS];
  logic [31:0] wr_data_arr   [NCLIENTS];

  genvar gi;
  generate
    for (gi = 0; gi < NCLIENTS; gi++) begin : g_unpack
      assign rd_addr_arr[gi]   = cli_rd_addr[32*gi +: 32];
      assign rd_handle_arr[gi] = cli_rd_handle[32*gi +: 32];
      assign wr_addr_arr[gi]   = cli_wr_addr[32*gi +: 32];
      assign wr_handle_arr[gi] = cli_wr_handle[32*gi +: 32];
      assign wr_data_arr[gi]   = cli_wr_data[32*gi +: 32];
    end
  endgenerate

  // Returns {found, index} of the first requester after 'last', wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NCLIENTS-1:0] req,
                                          input logic [IW-1:0] last);
    logic          found;
    logic [IW-1:0] sel;
    int            idx;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NCLIENTS; k++) begin
      idx = (int'(last) + k) % NCLIENTS;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
    return {found, sel};
  endfunction

  logic [IW:0]   wr_pick;
  logic [IW:0]   rd_pick;
  logic [IW-1:0] wr_sel;
  logic [IW-1:0] rd_sel;
  logic          wr_grant;
  logic          rd_grant;
  logic          rd_done;
  logic          burst_cond;

  always_comb begin
    wr_pick  = rr_pick(cli_wr_valid, wr_last_reg);
    rd_pick  = rr_pick(cli_rd_valid, rd_last_reg);
    wr_sel   = wr_pick[IW-1:0];
    rd_sel   = rd_pick[IW-1:0];
    // A full burst forces one write-free cycle so a waiting read can go out.
    wr_grant = !RST && wr_pick[IW] && (wr_burst_reg != 8'(MAX_WR_BURST));
    rd_grant = !RST && (state_reg == RD_IDLE) && rd_pick[IW] &&
               dma_rdy_readrequest && !wr_grant;
    rd_done  = !RST && (state_reg == RD_BUSY) && dma_rdy_readresponse &&
               cli_rsp_ready[owner_reg];
    burst_cond = wr_grant && (state_reg == RD_IDLE) && (|cli_rd_valid);
  end

  always_comb begin
    cli_wr_ready  = wr_grant ? (NCLIENTS'(1) << wr_sel) : '0;
    cli_rd_ready  = rd_grant ? (NCLIENTS'(1) << rd_sel) : '0;
    cli_rsp_valid = '0;
    if (!RST && state_reg == RD_BUSY)
      cli_rsp_valid[owner_reg] = dma_rdy_readresponse;
  end

  assign cli_rsp_data           = dma_readresponse_data;
  assign dma_en_write32         = wr_grant;
  assign dma_write32_addr       = wr_addr_arr[wr_sel];
  assign dma_write32_handle     = wr_handle_arr[wr_sel];
  assign dma_write32_data       = wr_data_arr[wr_sel];
  assign dma_en_readrequest     = rd_grant;
  assign dma_readrequest_addr   = rd_addr_arr[rd_sel];
  assign dma_readrequest_handle = rd_handle_arr[rd_sel];
  assign dma_en_readresponse    = rd_done;
  assign rd_count               = rd_count_reg;
  assign wr_count               = wr_count_reg;
  assign busy                   = (state_reg == RD_BUSY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= RD_IDLE;
      owner_reg    <= '0;
      rd_last_reg  <= IW'(NCLIENTS - 1);
      wr_last_reg  <= IW'(NCLIENTS - 1);
      wr_burst_reg <= '0;
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else begin
      wr_burst_reg <= burst_cond ? 8'(wr_burst_reg + 8'd1) : 8'd0;
      if (wr_grant) begin
        wr_last_reg  <= wr_sel;
        wr_count_reg <= wr_count_reg + 32'd1;
      end
      if (rd_grant) begin
        state_reg   <= RD_BUSY;
        owner_reg   <= rd_sel;
        rd_last_reg <= rd_sel;
      end else if (rd_done) begin
        state_reg    <= RD_IDLE;
        rd_count_reg <= rd_count_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_xsim_dma_arbiter.sv
// Directed bench for xsim_dma_arbiter with a small memory-backed DMA model.
module tb_xsim_dma_arbiter;
  localparam int N = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  cli_rd_valid, cli_rd_ready, cli_rsp_valid, cli_rsp_ready;
  logic [N-1:0]  cli_wr_valid, cli_wr_ready;
  logic [32*N-1:0] cli_rd_addr, cli_rd_handle, cli_wr_addr, cli_wr_handle, cli_wr_data;
  logic [31:0]   cli_rsp_data;
  logic          dma_rdy_readrequest, dma_en_readrequest;
  logic [31:0]   dma_readrequest_addr, dma_readrequest_handle;
  logic          dma_rdy_readresponse, dma_en_readresponse;
  logic [31:0]   dma_readresponse_data;
  logic          dma_en_write32;
  logic [31:0]   dma_write32_addr, dma_write32_handle, dma_write32_data;
  logic [31:0]   rd_count, wr_count;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  xsim_dma_arbiter #(.NCLIENTS(N), .MAX_WR_BURST(8)) dut (
    .CLK(CLK), .RST(RST),
    .cli_rd_valid(cli_rd_valid), .cli_rd_ready(cli_rd_ready),
    .cli_rd_addr(cli_rd_addr), .cli_rd_handle(cli_rd_handle),
    .cli_rsp_valid(cli_rsp_valid), .cli_rsp_ready(cli_rsp_ready),
    .cli_rsp_data(cli_rsp_data),
    .cli_wr_valid(cli_wr_valid), .cli_wr_ready(cli_wr_ready),
    .cli_wr_addr(cli_wr_addr), .cli_wr_handle(cli_wr_handle), .cli_wr_data(cli_wr_data),
    .dma_rdy_readrequest(dma_rdy_readrequest), .dma_en_readrequest(dma_en_readrequest),
    .dma_readrequest_addr(dma_readrequest_addr), .dma_readrequest_handle(dma_readrequest_handle),
    .dma_rdy_readresponse(dma_rdy_readresponse), .dma_en_readresponse(dma_en_readresponse),
    .dma_readresponse_data(dma_readresponse_data),
    .dma_en_write32(dma_en_write32), .dma_write32_addr(dma_write32_addr),
    .dma_write32_handle(dma_write32_handle), .dma_write32_data(dma_write32_data),
    .rd_count(rd_count), .wr_count(wr_count), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // DMA model: writes land in memory, a read request registers its data.
  logic [31:0] mem [256];
  logic        pend;
  logic [31:0] pend_data;
  assign dma_rdy_readresponse  = pend;
  assign dma_readresponse_data = pend_data;
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge CLK) begin
    if (RST) pend <= 1'b0;
    else begin
      if (dma_en_write32) mem[dma_write32_addr[7:0]] <= dma_write32_data;
      if (dma_en_readrequest) begin
        pend      <= 1'b1;
        pend_data <= mem[dma_readrequest_addr[7:0]];
      end else if (dma_en_readresponse) pend <= 1'b0;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    cli_rd_valid = '0; cli_wr_valid = '0; cli_rsp_ready = '0;
    cli_rd_addr = '0; cli_rd_handle = '0;
    cli_wr_addr = '0; cli_wr_handle = '0; cli_wr_data = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    dma_rdy_readrequest = 1'b1;
    RST = 1'b1;
    clear_inputs();
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
    chk("rst_en_w32", 32'(dma_en_write32), 32'd0);

    // Single write from client 2
    cli_wr_valid = 4'b0100;
    cli_wr_addr[64 +: 32] = 32'h10;
    cli_wr_data[64 +: 32] = 32'hdeadbeef;
    cli_wr_handle[64 +: 32] = 32'h7;
    #1;
    chk("w1_en", 32'(dma_en_write32), 32'd1);
    chk("w1_addr", dma_write32_addr, 32'h10);
    chk("w1_data", dma_write32_data, 32'hdeadbeef);
    chk("w1_handle", dma_write32_handle, 32'h7);
    chk("w1_ready", 32'(cli_wr_ready), 32'h4);
    tick();
    cli_wr_valid = '0;
    #1;
    chk("w1_count", wr_count, 32'd1);

    // Round-robin over four writers from a fresh reset
    do_reset();
    cli_wr_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'(cli_wr_ready), 32'(1 << (k % 4)));
      tick();
    end
    cli_wr_valid = '0;
    #1;
    chk("rr_count", wr_count, 32'd8);

    // Write and read of the same address from client 1
    do_reset();
    cli_rsp_ready = 4'b1111;
    cli_wr_valid = 4'b0010; cli_wr_addr[32 +: 32] = 32'h20; cli_wr_data[32 +: 32] = 32'h55;
    cli_rd_valid = 4'b0010; cli_rd_addr[32 +: 32] = 32'h20;
    #1;
    chk("wr_first_en_w", 32'(dma_en_write32), 32'd1);
    chk("wr_first_en_r", 32'(dma_en_readrequest), 32'd0);
    tick();
    cli_wr_valid = '0;
    #1;
    chk("rd_next_en_r", 32'(dma_en_readrequest), 32'd1);
    chk("rd_next_ready", 32'(cli_rd_ready), 32'h2);
    chk("rd_next_addr", dma_readrequest_addr, 32'h20);
    tick();
    cli_rd_valid = '0;
    #1;
    chk("rsp_busy", 32'(busy), 32'd1);
    chk("rsp_valid", 32'(cli_rsp_valid), 32'h2);
    chk("rsp_data", cli_rsp_data, 32'h55);
    chk("rsp_en", 32'(dma_en_readresponse), 32'd1);
    tick();
    #1;
    chk("rsp_done_busy", 32'(busy), 32'd0);
    chk("rsp_done_count", rd_count, 32'd1);

    // Client 3 read held off by its response-ready for five cycles
    do_reset();
    cli_rd_valid = 4'b1000; cli_rd_addr[96 +: 32] = 32'h10;
    #1;
    chk("hold_grant", 32'(cli_rd_ready), 32'h8);
    tick();
    cli_rd_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("hold_rsp%0d", k), 32'(cli_rsp_valid), 32'h8);
      chk($sformatf("hold_noreq%0d", k), 32'(dma_en_readrequest), 32'd0);
      chk($sformatf("hold_noen%0d", k), 32'(dma_en_readresponse), 32'd0);
      tick();
    end
    cli_rsp_ready = 4'b1000;
    #1;
    chk("hold_en", 32'(dma_en_readresponse), 32'd1);
    chk("hold_data", cli_rsp_data, 32'hdeadbeef);
    tick();
    #1;
    chk("hold_count", rd_count, 32'd1);
    chk("hold_next_grant", 32'(cli_rd_ready), 32'h1);
    tick();
    cli_rd_valid = '0; cli_rsp_ready = 4'b1111;
    #1;
    chk("hold_next_rsp", 32'(cli_rsp_valid), 32'h1);
    tick();

    // Write burst limit with a waiting reader
    do_reset();
    cli_rsp_ready = 4'b1111;
    cli_wr_valid = 4'b0101;
    cli_rd_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("burst_w%0d", k), 32'(cli_wr_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
      chk($sformatf("burst_nor%0d", k), 32'(dma_en_readrequest), 32'd0);
      tick();
    end
    #1;
    chk("stall_en_w", 32'(dma_en_write32), 32'd0);
    chk("stall_en_r", 32'(dma_en_readrequest), 32'd1);
    chk("stall_rd_ready", 32'(cli_rd_ready), 32'h2);
    tick();
    cli_rd_valid = '0;
    #1;
    chk("resume_en_w", 32'(dma_en_write32), 32'd1);
    chk("resume_ready", 32'(cli_wr_ready), 32'h1);
    tick();
    cli_wr_valid = '0;
    #1;
    chk("resume_count", wr_count, 32'd9);

    // Reset in the middle of a read
    cli_rsp_ready = '0;
    cli_rd_valid = 4'b0100;
    #1;
    chk("mid_grant", 32'(cli_rd_ready), 32'h4);
    tick();
    cli_rd_valid = '0;
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    cli_rd_valid = 4'b1111;
    tick();
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp", 32'(cli_rsp_valid), 32'd0);
    chk("mid_rst_rdy", 32'(cli_rd_ready), 32'd0);
    chk("mid_rst_en_r", 32'(dma_en_readrequest), 32'd0);
    RST = 1'b0;
    #1;
    chk("mid_after_grant", 32'(cli_rd_ready), 32'h1);
    tick();
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/xsim_dma_arbiter.md
# xsim_dma_arbiter

Shares the single simulation DMA port (readrequest/readresponse/write32 of the xsim DMA model) between NCLIENTS requesters. Round-robin arbitration on separate read and write channels, one outstanding read, and response routing back to the issuing client. Writes take precedence over reads in the same cycle, with a bounded write-burst limit so reads are not starved. Sits between the portal/DMA clients in mkXsimTop and the DPI DMA model.

## Interface
- NCLIENTS, 4: number of requesters, 2..16
- MAX_WR_BURST, 8: consecutive write cycles allowed while a read waits, 1..255
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high; clock CLK
- cli_rd_valid  in  NCLIENTS  per-client read request valid
- cli_rd_ready  out  NCLIENTS  read request accepted this cycle (one-hot or zero)
- cli_rd_addr, cli_rd_handle  in  32*NCLIENTS each  packed; client i at [32i+31:32i]
- cli_rsp_valid  out  NCLIENTS  read data valid to owning client (one-hot or zero)
- cli_rsp_ready  in  NCLIENTS  client accepts read data
- cli_rsp_data  out  32  read data, broadcast to all clients
- cli_wr_valid  in  NCLIENTS  write request valid
- cli_wr_ready  out  NCLIENTS  write accepted this cycle (one-hot or zero)
- cli_wr_addr, cli_wr_handle, cli_wr_data  in  32*NCLIENTS each  packed write fields
- dma_rdy_readrequest  in  1  model can accept a read
- dma_en_readrequest  out  1  issue read
- dma_readrequest_addr, dma_readrequest_handle  out  32 each
- dma_rdy_readresponse  in  1  model holds read data
- dma_en_readresponse  out  1  consume read data
- dma_readresponse_data  in  32
- dma_en_write32  out  1  issue write (always accepted by model)
- dma_write32_addr, dma_write32_handle, dma_write32_data  out  32 each
- rd_count, wr_count  out  32 each  completed reads / issued writes, wrap at 2^32
- busy  out  1  read channel in RD_BUSY

## Operation
- Write channel: each cycle, if any cli_wr_valid and not write-stalled, grant the first valid client searching from wr_last+1 (mod NCLIENTS); drive its fields on dma_write32_*, assert dma_en_write32 and cli_wr_ready[i]; wr_last <= i; wr_count += 1.
- Read channel FSM, states RD_IDLE, RD_BUSY:
  - RD_IDLE: if any cli_rd_valid, dma_rdy_readrequest=1 and no write granted this cycle, grant first valid from rd_last+1; assert dma_en_readrequest, cli_rd_ready[i]; owner <= i, rd_last <= i, go RD_BUSY.
  - RD_BUSY: cli_rsp_valid[owner] = dma_rdy_readresponse; cli_rsp_data = dma_readresponse_data. When both dma_rdy_readresponse and cli_rsp_ready[owner]: dma_en_readresponse=1, rd_count += 1, go RD_IDLE. Otherwise hold; no new read issued.
- Ordering: write priority guarantees every read observes all writes issued in earlier cycles; a read and a write never issue in the same cycle.
- Burst limit: wr_burst counter increments on each write cycle while state=RD_IDLE and any cli_rd_valid; resets to 0 on any cycle without that condition. When wr_burst == MAX_WR_BURST, write grant suppressed for one cycle (write-stall), the read issues if dma_rdy_readrequest, and wr_burst clears.
- Ready/valid: cli_*_ready depend combinationally on cli_*_valid; clients must not make valid depend on ready. A client deasserting valid without ready is legal (request dropped).

## Timing
- Reset: all out enables/readies/rsp_valid 0, state RD_IDLE, owner 0, rd_last = wr_last = NCLIENTS-1 (client 0 wins first), wr_burst 0, rd_count = wr_count = 0, busy 0. Effective the cycle after RST sampled high; RST mid-read abandons owner (the DMA model shares RST and drops its data).
- Grants combinational in cycle T; pointers, owner, counters update at the edge ending T.
- Read latency: request T, cli_rsp_valid earliest T+1 (model registers data), completion T+1, next read issue earliest T+2; peak read throughput 1 per 2 cycles.
- Write throughput 1 per cycle; zero latency to dma_en_write32.
- Round-robin wrap: after client NCLIENTS-1, search resumes at 0.

## Test plan
- Reset then single write from client 2 (addr 0x10, data 0xdeadbeef) -> dma_en_write32 same cycle with those fields, cli_wr_ready=0100, wr_count=1.
- All 4 clients hold cli_wr_valid 8 cycles -> grant order 0,1,2,3,0,1,2,3; wr_count=8.
- Client 1 writes 0x55 to addr 0x20 and reads 0x20 same cycle -> write first, read issues next cycle, cli_rsp_valid[1] with data 0x55 one cycle later.
- Client 3 read with cli_rsp_ready low 5 cycles -> busy=1, cli_rsp_valid[3] held, no dma_en_readrequest; completes when ready rises, rd_count=1.
- Clients 0,2 write continuously, client 1 reads, MAX_WR_BURST=8 -> exactly 8 writes, one stall cycle with read issue, writes resume.
- RST asserted while RD_BUSY -> next cycle all outputs 0, busy=0, client 0 wins next read.
